// File: rtl/seq_core.sv
// seq_core: multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 16-bit ISA
// with parametrised data/address width and req/ack memory ports.
module seq_core #(
    parameter int            DW       = 16,
    parameter int            AW       = 9,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          ck,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          retire,
    output logic [31:0]   instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] c_q, c_d;
    logic [DW-1:0] rf_q [16];
    logic [DW-1:0] rf_d [16];
    logic [31:0]   instret_q, instret_d;

    logic [3:0]    op, rd, rs, rb;
    logic [7:0]    imm;
    logic [11:0]   tgt;
    logic [AW-1:0] pc_inc, br_tgt, jmp_tgt, mem_addr;
    logic [DW-1:0] alu_res, wr_data;
    logic          wr_en, ret;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs  = ir_q[7:4];
    assign rb  = ir_q[3:0];
    assign imm = ir_q[7:0];
    assign tgt = ir_q[11:0];

    assign pc_inc   = pc_q + AW'(1);
    assign br_tgt   = pc_inc + AW'($signed(imm));
    assign jmp_tgt  = AW'(tgt);
    assign mem_addr = AW'(a_q + DW'(rb));

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_LI:   alu_res = DW'($signed(imm));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        rf_d      = rf_q;
        instret_d = instret_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        ret       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rb];
                c_d     = rf_q[rd];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                ret     = 1'b1;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI: begin
                        wr_en   = 1'b1;
                        wr_data = alu_res;
                    end
                    OP_LD, OP_ST: begin
                        ret     = 1'b0;
                        pc_d    = pc_q;
                        state_d = S_MEM;
                    end
                    OP_JMP: pc_d = jmp_tgt;
                    OP_BZ:  pc_d = (c_q == '0) ? br_tgt : pc_inc;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    wr_en   = (op == OP_LD);
                    wr_data = dmem_rdata;
                    ret     = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
        // r0 is hardwired: writes to it still retire but are dropped here
        if (wr_en && rd != 4'd0) begin
            rf_d[rd] = wr_data;
        end
        if (ret) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            instret_q <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            instret_q <= instret_d;
            rf_q      <= rf_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM) && !rst;
    assign dmem_we    = (op == OP_ST);
    assign dmem_addr  = mem_addr;
    assign dmem_wdata = c_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign retire     = ret && !rst;
    assign instret    = instret_q;

endmodule

// File: tb/tb_seq_core.sv
// Scoreboard bench for seq_core: ISA-level reference model feeds expected
// retires and data accesses; a monitor pops and compares them.
module tb_seq_core;

    localparam int            DW  = 16;
    localparam int            AW  = 9;
    localparam logic [AW-1:0] RPC = '0;
    localparam int            MSZ = 1 << AW;
    localparam int            DM  = (1 << DW) - 1;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req, imem_ack = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata = '0;
    logic          dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
    logic [AW-1:0] pc;
    logic          halted, retire;
    logic [31:0]   instret;

    logic          imem_req_b, imem_ack_b = 1'b0;
    logic [11:0]   imem_addr_b;
    logic [15:0]   imem_rdata_b = '0;
    logic          dmem_req_b, dmem_we_b, dmem_ack_b = 1'b0;
    logic [11:0]   dmem_addr_b;
    logic [31:0]   dmem_wdata_b, dmem_rdata_b = '0;
    logic [11:0]   pc_b;
    logic          halted_b, retire_b;
    logic [31:0]   instret_b;
    logic [31:0]   st_data_b;
    logic [11:0]   st_addr_b;

    always #5 ck = ~ck;

    seq_core #(.DW(DW), .AW(AW), .RESET_PC(RPC)) dut (
        .ck(ck), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .halted(halted), .retire(retire), .instret(instret)
    );

    seq_core #(.DW(32), .AW(12), .RESET_PC(12'h100)) dut_b (
        .ck(ck), .rst(rst),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b),
        .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
        .dmem_ack(dmem_ack_b), .dmem_rdata(dmem_rdata_b),
        .pc(pc_b), .halted(halted_b), .retire(retire_b),
        .instret(instret_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   cnt;
    } ret_t;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    ret_t ret_q[$];
    acc_t acc_q[$];
    int   ret_cycles[$];
    int   halt_cycle = -1;
    int   cyc = 0;

    logic [15:0]   imem [MSZ];
    logic [DW-1:0] dmem [MSZ];
    logic [DW-1:0] dmem_init [MSZ];

    bit            m_halts;
    int            m_count;
    logic [AW-1:0] m_halt_pc, m_final_pc;

    // Reference model: executes the program instruction by instruction
    task automatic model_run(input int max_steps);
        int r [16];
        int md [MSZ];
        int p, np, op, rd, rs, rb, simm, a;
        logic [15:0] w;
        for (int i = 0; i < 16; i++) r[i] = 0;
        for (int i = 0; i < MSZ; i++) md[i] = int'(dmem_init[i]);
        p = int'(RPC);
        m_count = 0;
        m_halts = 0;
        while (m_count < max_steps && !m_halts) begin
            w  = imem[p];
            op = int'(w[15:12]);
            rd = int'(w[11:8]);
            rs = int'(w[7:4]);
            rb = int'(w[3:0]);
            simm = (w[7:0] >= 128) ? int'(w[7:0]) - 256 : int'(w[7:0]);
            np = (p + 1) % MSZ;
            ret_q.push_back('{pc: AW'(p), cnt: 32'(m_count)});
            m_count++;
            case (op)
                1: r[rd] = (r[rs] + r[rb]) & DM;
                2: r[rd] = (r[rs] - r[rb]) & DM;
                3: r[rd] = r[rs] & r[rb];
                4: r[rd] = r[rs] | r[rb];
                5: r[rd] = r[rs] ^ r[rb];
                6: r[rd] = simm & DM;
                7: begin
                    a = (r[rs] + rb) % MSZ;
                    acc_q.push_back('{we: 1'b0, addr: AW'(a), data: '0});
                    r[rd] = md[a];
                end
                8: begin
                    a = (r[rs] + rb) % MSZ;
                    acc_q.push_back('{we: 1'b1, addr: AW'(a),
                                      data: DW'(r[rd])});
                    md[a] = r[rd];
                end
                9: np = int'(w[11:0]) % MSZ;
                10: if (r[rd] == 0) np = ((p + 1 + simm) % MSZ + MSZ) % MSZ;
                15: begin
                    m_halts = 1;
                    m_halt_pc = AW'(p);
                    np = p;
                end
                default: ;
            endcase
            r[0] = 0;
            p = np;
        end
        m_final_pc = AW'(p);
    endtask

    int  iw_min = 0, iw_max = 0, dw_min = 0, dw_max = 0;
    bit  dstall = 0;
    int  iwait = -1, dwait = -1;
    logic [AW-1:0] ia0, da0;
    logic          dwe0;
    logic [DW-1:0] dwd0;

    // Memory responder with random wait states and spurious acks
    always @(negedge ck) begin
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (rst) begin
            iwait = -1;
            dwait = -1;
        end else begin
            if (imem_req) begin
                if (iwait < 0) begin
                    iwait = $urandom_range(iw_max, iw_min);
                    ia0 = imem_addr;
                end
                if (iwait == 0) begin
                    chk("imem_addr_hold", imem_addr, ia0);
                    imem_ack = 1'b1;
                    imem_rdata = imem[imem_addr];
                    iwait = -1;
                end else begin
                    iwait--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                imem_ack = 1'b1;
                imem_rdata = 16'($urandom);
            end
            if (dmem_req) begin
                if (dwait < 0) begin
                    dwait = $urandom_range(dw_max, dw_min);
                    da0 = dmem_addr;
                    dwe0 = dmem_we;
                    dwd0 = dmem_wdata;
                end
                if (dwait == 0 && !dstall) begin
                    chk("dmem_hold", {dmem_we, dmem_addr, dmem_wdata},
                        {dwe0, da0, dwd0});
                    dmem_ack = 1'b1;
                    dmem_rdata = dmem[dmem_addr];
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    dwait = -1;
                end else if (dwait > 0) begin
                    dwait--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dmem_ack = 1'b1;
                dmem_rdata = DW'($urandom);
            end
        end
    end

    // Zero-wait memory for the wide instance
    always @(negedge ck) begin
        #1;
        imem_ack_b = imem_req_b;
        case (imem_addr_b)
            12'h100: imem_rdata_b = 16'h61FF;
            12'h101: imem_rdata_b = 16'h8100;
            default: imem_rdata_b = 16'hF000;
        endcase
        dmem_ack_b = dmem_req_b;
        if (dmem_req_b && dmem_we_b) begin
            st_addr_b = dmem_addr_b;
            st_data_b = dmem_wdata_b;
        end
    end

    // Monitor: pops scoreboard entries on retire and data ack
    always @(negedge ck) begin
        acc_t ea;
        ret_t er;
        #2;
        if (rst) begin
            cyc = 0;
            chk("rst_gates_outputs", {imem_req, dmem_req, retire}, 3'b000);
        end else begin
            cyc++;
            if (dmem_req && dmem_ack) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access actual=addr %0h required=none",
                             dmem_addr);
                end else begin
                    ea = acc_q.pop_front();
                    chk("acc_we", dmem_we, ea.we);
                    chk("acc_addr", dmem_addr, ea.addr);
                    if (ea.we) chk("acc_wdata", dmem_wdata, ea.data);
                end
            end
            if (retire) begin
                ret_cycles.push_back(cyc);
                if (ret_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire actual=pc %0h required=none",
                             pc);
                end else begin
                    er = ret_q.pop_front();
                    chk("retire_pc", pc, er.pc);
                    chk("retire_instret", instret, er.cnt);
                end
            end
            if (halted && halt_cycle < 0) halt_cycle = cyc;
        end
    end

    task automatic load(input logic [15:0] w[$]);
        for (int i = 0; i < MSZ; i++) imem[i] = 16'hF000;
        foreach (w[i]) imem[i] = w[i];
    endtask

    task automatic set_waits(input int a, input int b, input int c,
                             input int d);
        iw_min = a;
        iw_max = b;
        dw_min = c;
        dw_max = d;
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        #3;
        chk("reset_pc", pc, RPC);
        chk("reset_halted", halted, 1'b0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_retire", retire, 1'b0);
        chk("wide_reset_addr", imem_addr_b, 12'h100);
        st_data_b = '0;
        st_addr_b = 12'hFFF;
        @(negedge ck);
        ret_cycles.delete();
        halt_cycle = -1;
        rst = 1'b0;
    endtask

    task automatic run_prog(input string name, input int max_steps,
                            input int budget);
        int n = 0;
        ret_q.delete();
        acc_q.delete();
        model_run(max_steps);
        for (int i = 0; i < MSZ; i++) dmem[i] = dmem_init[i];
        do_reset();
        while (n < budget && (m_halts ? !halted : ret_q.size() != 0)) begin
            @(negedge ck);
            n++;
        end
        #3;
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d required=<%0d", name, n, budget);
        end
        chk({name, "_instret"}, instret, 32'(m_count));
        chk({name, "_ret_left"}, ret_q.size(), 0);
        chk({name, "_acc_left"}, acc_q.size(), 0);
        if (m_halts) begin
            chk({name, "_halt_cycle"}, halt_cycle,
                ret_cycles.size() > 0 ? ret_cycles[$] + 1 : -2);
            repeat (3) @(negedge ck);
            #3;
            chk({name, "_halted_stays"}, halted, 1'b1);
            chk({name, "_halt_pc"}, pc, m_halt_pc);
            chk({name, "_instret_held"}, instret, 32'(m_count));
        end else begin
            chk({name, "_pc"}, pc, m_final_pc);
        end
    endtask

    task automatic check_cycles(input string name, input int exp[$]);
        chk({name, "_nret"}, ret_cycles.size(), exp.size());
        foreach (exp[i]) begin
            if (i < ret_cycles.size()) chk({name, "_cyc"}, ret_cycles[i], exp[i]);
        end
    endtask

    task automatic gen_random();
        int len, k;
        logic [15:0] w;
        len = $urandom_range(8, 30);
        for (int i = 0; i < MSZ; i++) imem[i] = 16'hF000;
        for (int i = 0; i < len; i++) begin
            k = $urandom_range(0, 13);
            case (k)
                0: w = {4'h0, 12'($urandom)};
                1, 2, 3, 4, 5: w = {4'(k), 12'($urandom)};
                6, 7, 8: w = {4'h6, 12'($urandom)};
                9: w = {4'h7, 12'($urandom)};
                10: w = {4'h8, 12'($urandom)};
                11: w = {4'h9, 12'(i + 1 + $urandom_range(0, 3))};
                12: w = {4'hA, 4'($urandom), 8'($urandom_range(0, 3))};
                default: w = {4'($urandom_range(11, 14)), 12'($urandom)};
            endcase
            imem[i] = w;
        end
        for (int i = 0; i < MSZ; i++) dmem_init[i] = DW'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MSZ; i++) dmem_init[i] = DW'($urandom);

        set_waits(0, 0, 0, 0);
        load('{16'h6105, 16'h62FD, 16'h1312, 16'hF000});
        run_prog("basic", 100, 200);
        check_cycles("basic", '{3, 6, 9, 12});
        chk("basic_halt_at_13", halt_cycle, 13);
        chk("wide_store_data", st_data_b, 32'hFFFF_FFFF);
        chk("wide_store_addr", st_addr_b, 12'h000);
        chk("wide_halted", halted_b, 1'b1);
        chk("wide_instret", instret_b, 32'd3);

        load('{16'h6105, 16'h62FD, 16'h1312, 16'h8300, 16'hF000});
        run_prog("add_store", 100, 200);

        set_waits(2, 2, 0, 0);
        load('{16'h6105, 16'h62FD, 16'h1312, 16'hF000});
        run_prog("fetch_wait", 100, 300);
        check_cycles("fetch_wait", '{5, 10, 15, 20});

        set_waits(0, 0, 3, 3);
        load('{16'h617E, 16'h8103, 16'h7403, 16'h8405, 16'hF000});
        run_prog("ldst", 100, 300);
        check_cycles("ldst", '{3, 10, 17, 24, 27});

        set_waits(0, 0, 0, 0);
        load('{16'hA0FF});
        run_prog("self_loop", 3, 100);

        load('{16'hA101, 16'hF000, 16'h6101, 16'h91FF});
        imem[MSZ-1] = 16'h0000;
        run_prog("pc_wrap", 100, 200);

        load('{16'h6103, 16'h62FF, 16'h1112, 16'hA101, 16'hA0FD, 16'hF000});
        run_prog("countdown", 100, 400);

        // reset while a store waits in MEM
        load('{16'h617E, 16'h8103});
        ret_q.delete();
        acc_q.delete();
        model_run(1);
        dstall = 1;
        do_reset();
        begin
            int n = 0;
            while (n < 50 && !dmem_req) begin
                @(negedge ck);
                n++;
            end
            chk("mem_wait_reached", dmem_req, 1'b1);
        end
        repeat (2) @(negedge ck);
        rst = 1'b1;
        #3;
        chk("rst_mid_dmem_req", dmem_req, 1'b0);
        chk("rst_mid_retire", retire, 1'b0);
        @(negedge ck);
        #3;
        chk("rst_mid_pc", pc, RPC);
        chk("rst_mid_instret", instret, 32'd0);
        chk("rst_mid_ret_left", ret_q.size(), 0);
        dstall = 0;

        for (int t = 0; t < 24; t++) begin
            set_waits(0, $urandom_range(0, 3), 0, $urandom_range(0, 3));
            gen_random();
            run_prog("random", 200, 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_core.md
# seq_core

Parametrised multi-cycle successor to the fixed-width PC/Fetch/Decode/Ex datapath. It executes the team's 16-bit instruction set with configurable data width, address width and reset vector, over separate instruction and data memory ports with req/ack handshakes. It replaces the free-running, self-toggling clock loop with a proper synchronous reset, an FSM sequencer, a halted status output and a retire counter. It is the top-level compute block fed by external instruction and data memories.

## Interface
- DW, 16: register/data width, ≥16.
- AW, 9: instruction/data address width, 4..16.
- RESET_PC, 0: PC value after reset (AW bits).
- ck  in  1: clock, all state on rising edge.
- rst  in  1: reset. One clock; reset is synchronous and active-high.
- imem_req  out  1: instruction fetch request.
- imem_addr  out  AW: fetch address (= pc).
- imem_ack  in  1: fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  16: instruction word.
- dmem_req  out  1: data access request.
- dmem_we  out  1: 1 = store, 0 = load.
- dmem_addr  out  AW: data address.
- dmem_wdata  out  DW: store data.
- dmem_ack  in  1: access complete; dmem_rdata valid this cycle for loads.
- dmem_rdata  in  DW: load data.
- pc  out  AW: current program counter.
- halted  out  1: core stopped on HALT.
- retire  out  1: one-cycle pulse per completed instruction.
- instret  out  32: retired-instruction count, wraps at 2^32.

## Operation
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rb/disp4=[3:0], imm=[7:0], tgt=[11:0].
- 16 registers, DW bits. r0 reads 0 and ignores writes.
- 0 NOP.
- 1 ADD rd=rs+rb. 2 SUB rd=rs−rb. 3 AND. 4 OR. 5 XOR. All results are mod 2^DW.
- 6 LI: rd = sign-extended imm.
- 7 LD: rd = mem[rs + zext(disp4)]. 8 ST: mem[rs + zext(disp4)] = rd. Address is truncated to the low AW bits.
- 9 JMP: pc = tgt truncated or zero-extended to AW.
- A BZ: if rd==0 then pc = pc+1+sext(imm), else pc+1. Result is mod 2^AW.
- F HALT. Opcodes B–E execute as NOP.
- Non-branch instructions set pc = pc+1 mod 2^AW.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack, latch the instruction → DECODE.
  - DECODE: read rs, rb, rd → EXEC.
  - EXEC: ALU/LI write back, pc update, retire → FETCH. LD/ST → MEM. HALT: retire → HALT.
  - MEM: dmem_req=1; addr, we and wdata held stable. On dmem_ack: LD writes rd, pc+1, retire → FETCH.
  - HALT: no requests, halted=1. Exit only via rst.
- The retire pulse and the instret increment occur in the same cycle as the writeback and pc update.

## Timing
- While rst is sampled high, the following take effect at the next edge:
  - state=FETCH, pc=RESET_PC, all registers 0, instret 0.
  - retire 0, halted 0.
- imem_req and dmem_req are gated by rst combinationally: low in every cycle rst is high.
- Requests are combinational from state. A zero-wait ack, high in the same cycle as req, is legal.
- ALU/LI/JMP/BZ/NOP take 3 cycles (FETCH, DECODE, EXEC) with zero-wait memory. Each extra fetch wait state adds 1.
- LD/ST take 4 cycles minimum. Each extra data wait state adds 1.
- Request hold: once asserted, req and its address/data stay constant until the ack cycle. req deasserts the cycle after the ack.
- Acks arriving while the corresponding req is low are ignored.
- Reset mid-operation: an outstanding fetch or data access is abandoned. No register write, no retire, no store completion is signalled.
- halted rises the cycle after HALT's retire pulse and then stays 1. pc holds the HALT address + 0 (not incremented).
- A write to r0 completes and retires, but r0 stays 0.
- pc wraps from 2^AW−1 to 0. A BZ target computed below 0 wraps modulo 2^AW.

## Test plan
- Reset then zero-wait program LI r1,5; LI r2,−3; ADD r3,r1,r2; HALT → r3=2, retire pulses at cycles 3,6,9,12, halted=1 at 13, instret=4.
- Fetch wait states: imem_ack delayed 2 cycles on every fetch → imem_addr stable throughout, ADD completes in 5 cycles.
- LI r1,0x7E; ST r1→[r0+3]; LD r4←[r0+3] with dmem_ack delayed 3 cycles → dmem_addr=3, dmem_we=1 then 0, r4=0x007E, LD retires 7 cycles after fetch start.
- BZ r0,−1 at pc=0 with AW=9 → pc=0 (self-loop). JMP 0x1FF; NOP → pc wraps 0x1FF→0x000.
- rst asserted during a MEM wait on ST → dmem_req low that cycle, no retire, pc=RESET_PC, instret=0.
- Parameters DW=32, AW=12, RESET_PC=0x100: LI r1,−1 → r1=0xFFFFFFFF. First imem_addr=0x100.
